// File: rtl/bridge_rom_loader.sv
// Splits 32-bit big-endian bridge writes into two 16-bit memory writes, buffered in a small FIFO.
// Latency: write in cycle N reaches mem_valid in N+2; one 16-bit word per cycle while mem_ready holds.
// Backpressure: the bridge is never stalled; writes arriving on a full FIFO are dropped and flagged.

// Generic synchronous FIFO: registered storage, head visible combinationally.
// Latency: a push is visible at the head on the next cycle. Backpressure: push ignored when full.
// Pop ignored when empty; a push and pop in the same cycle leave count unchanged.
module bridge_rom_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             head_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module bridge_rom_loader #(
    parameter logic [31:0] ROM_BYTES  = 32'h0010_0000,
    parameter int          ADDR_W     = 19,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bridge_wr,
    input  logic [31:0]       bridge_addr,
    input  logic [31:0]       bridge_wr_data,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_data,
    output logic              busy,
    output logic              overflow,
    output logic              out_of_range,
    output logic [31:0]       words_written
);
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } entry_t;

    typedef enum logic [1:0] {IDLE, HI, LO} state_t;

    state_t                  state, state_d;
    entry_t                  hold, hold_d, head, push_entry;
    logic                    in_range;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                    mem_valid_d;
    logic [ADDR_W-1:0]       mem_addr_d;
    logic [15:0]             mem_data_d;

    // Word address of the high half; the low half always sits at +1.
    assign in_range        = (bridge_addr < ROM_BYTES);
    assign push_entry.addr = {bridge_addr[ADDR_W:2], 1'b0};
    assign push_entry.data = bridge_wr_data;
    assign fifo_push       = bridge_wr && in_range && !fifo_full;

    bridge_rom_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_dat (push_entry),
        .pop      (fifo_pop),
        .head_dat (head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_d     = state;
        hold_d      = hold;
        fifo_pop    = 1'b0;
        mem_valid_d = mem_valid;
        mem_addr_d  = mem_addr;
        mem_data_d  = mem_data;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    hold_d      = head;
                    state_d     = HI;
                    mem_valid_d = 1'b1;
                    mem_addr_d  = head.addr;
                    mem_data_d  = head.data[31:16];
                end
            end
            HI: begin
                if (mem_ready) begin
                    state_d    = LO;
                    mem_addr_d = hold.addr + ADDR_W'(1);
                    mem_data_d = hold.data[15:0];
                end
            end
            LO: begin
                if (mem_ready) begin
                    // Chain straight into the next entry so there is no bubble.
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        hold_d     = head;
                        state_d    = HI;
                        mem_addr_d = head.addr;
                        mem_data_d = head.data[31:16];
                    end else begin
                        state_d     = IDLE;
                        mem_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                mem_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            hold          <= '0;
            mem_valid     <= 1'b0;
            mem_addr      <= '0;
            mem_data      <= '0;
            overflow      <= 1'b0;
            out_of_range  <= 1'b0;
            words_written <= '0;
        end else begin
            state     <= state_d;
            hold      <= hold_d;
            mem_valid <= mem_valid_d;
            mem_addr  <= mem_addr_d;
            mem_data  <= mem_data_d;
            if (bridge_wr && !in_range)             out_of_range <= 1'b1;
            if (bridge_wr && in_range && fifo_full) overflow     <= 1'b1;
            if (mem_valid && mem_ready)             words_written <= words_written + 32'd1;
        end
    end

    assign busy = (fifo_count != '0) || (state != IDLE);
endmodule

// File: tb/tb_bridge_rom_loader.sv
// Bench for bridge_rom_loader: directed scenarios plus a paced random run,
// checked against a queue of expected 16-bit words built from accepted writes.
module tb_bridge_rom_loader;
    logic        clk = 1'b0;
    logic        reset;
    logic        bridge_wr;
    logic [31:0] bridge_addr;
    logic [31:0] bridge_wr_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [18:0] mem_addr;
    logic [15:0] mem_data;
    logic        busy;
    logic        overflow;
    logic        out_of_range;
    logic [31:0] words_written;

    bridge_rom_loader dut (
        .clk            (clk),
        .reset          (reset),
        .bridge_wr      (bridge_wr),
        .bridge_addr    (bridge_addr),
        .bridge_wr_data (bridge_wr_data),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .busy           (busy),
        .overflow       (overflow),
        .out_of_range   (out_of_range),
        .words_written  (words_written)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [18:0] a;
        logic [15:0] d;
    } word_t;

    word_t       q[$];
    int          tests = 0;
    int          fails = 0;
    bit          wr_accept = 1'b0;
    bit          prev_stall = 1'b0;
    logic [18:0] prev_addr;
    logic [15:0] prev_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: every accepted write becomes two words, high half first, at
    // word address (byte_addr / 4) * 2 and that plus one.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            check("busy", busy, q.size() != 0);
            if (mem_valid && q.size() == 0) check("spurious_valid", mem_valid, 1'b0);
            if (prev_stall) begin
                check("stall_valid", mem_valid, 1'b1);
                check("stall_addr", mem_addr, prev_addr);
                check("stall_data", mem_data, prev_data);
            end
            if (mem_valid && mem_ready && q.size() != 0) begin
                check("word_addr", mem_addr, q[0].a);
                check("word_data", mem_data, q[0].d);
                void'(q.pop_front());
            end
            prev_stall = mem_valid && !mem_ready;
            prev_addr  = mem_addr;
            prev_data  = mem_data;
            if (bridge_wr && wr_accept) begin
                logic [18:0] w;
                w = 19'((bridge_addr >> 2) << 1);
                q.push_back('{w, bridge_wr_data[31:16]});
                q.push_back('{w + 19'd1, bridge_wr_data[15:0]});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input bit acc);
        bridge_wr      = 1'b1;
        bridge_addr    = a;
        bridge_wr_data = d;
        wr_accept      = acc;
        step();
        bridge_wr = 1'b0;
        wr_accept = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((busy || q.size() != 0) && n < 400) begin
            step();
            n++;
        end
        check(name, n >= 400, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        bridge_wr = 1'b0;
        bridge_addr = '0;
        bridge_wr_data = '0;
        mem_ready = 1'b1;
        #1;
        idle(3);
        reset = 1'b0;
        check("rst_valid", mem_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_words", words_written, 32'd0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_oor", out_of_range, 1'b0);
        check("rst_addr", mem_addr, 19'd0);

        // Latency and first pair of words.
        drive(32'h0, 32'h1234_5678, 1'b1);
        check("lat_n1_valid", mem_valid, 1'b0);
        step();
        check("lat_n2_valid", mem_valid, 1'b1);
        check("lat_n2_addr", mem_addr, 19'h0);
        check("lat_n2_data", mem_data, 16'h1234);
        step();
        check("lat_n3_addr", mem_addr, 19'h1);
        check("lat_n3_data", mem_data, 16'h5678);
        step();
        check("lat_n4_busy", busy, 1'b0);
        check("lat_n4_words", words_written, 32'd2);

        // Stall with mem_ready low.
        mem_ready = 1'b0;
        drive(32'h100, 32'hCAFE_BABE, 1'b1);
        step();
        check("stall_hi_addr", mem_addr, 19'h80);
        check("stall_hi_data", mem_data, 16'hCAFE);
        idle(5);
        check("stall_still_valid", mem_valid, 1'b1);
        check("stall_still_addr", mem_addr, 19'h80);
        mem_ready = 1'b1;
        step();
        check("stall_lo_addr", mem_addr, 19'h81);
        check("stall_lo_data", mem_data, 16'hBABE);
        step();
        check("stall_done_valid", mem_valid, 1'b0);
        check("stall_words", words_written, 32'd4);

        // Fill: one entry parked in the serializer, then 8 fit and 2 are dropped.
        mem_ready = 1'b0;
        drive(32'h200, 32'h0A0A_0B0B, 1'b1);
        idle(2);
        for (int i = 0; i < 10; i++)
            drive(32'h1000 + 32'(i * 4), 32'h1111_0000 + 32'(i), i < 8);
        check("ovf_flag", overflow, 1'b1);
        check("ovf_words_held", words_written, 32'd4);
        check("ovf_queue", q.size(), 18);
        mem_ready = 1'b1;
        drain("ovf_drain_timeout");
        check("ovf_words", words_written, 32'd22);

        // Range boundary and ignored low address bits.
        drive(32'h0010_0000, 32'hDEAD_BEEF, 1'b0);
        idle(4);
        check("oor_flag", out_of_range, 1'b1);
        check("oor_busy", busy, 1'b0);
        check("oor_words", words_written, 32'd22);
        drive(32'h000F_FFFC, 32'h7777_8888, 1'b1);
        drive(32'h0000_0006, 32'h9999_AAAA, 1'b1);
        drain("edge_drain_timeout");
        check("edge_words", words_written, 32'd26);

        // Reset in LO with three entries queued.
        mem_ready = 1'b0;
        drive(32'h40, 32'hAAAA_5555, 1'b1);
        idle(2);
        drive(32'h44, 32'h1, 1'b1);
        drive(32'h48, 32'h2, 1'b1);
        drive(32'h4C, 32'h3, 1'b1);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check("pre_rst_lo_addr", mem_addr, 19'h21);
        check("pre_rst_lo_data", mem_data, 16'h5555);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_valid", mem_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_words", words_written, 32'd0);
        check("mid_rst_ovf", overflow, 1'b0);
        check("mid_rst_oor", out_of_range, 1'b0);
        mem_ready = 1'b1;
        idle(10);
        check("post_rst_words", words_written, 32'd0);

        // Paced random traffic with random mem_ready.
        begin
            int nw;
            int cyc;
            nw = 0;
            cyc = 0;
            while (nw < 1000 && cyc < 30000) begin
                mem_ready = ($urandom_range(0, 3) != 0);
                if (q.size() < 12 && $urandom_range(0, 1) == 1) begin
                    bridge_wr      = 1'b1;
                    bridge_addr    = 32'($urandom_range(0, 32'h000F_FFFF));
                    bridge_wr_data = $urandom;
                    wr_accept      = 1'b1;
                    nw++;
                end else begin
                    bridge_wr = 1'b0;
                    wr_accept = 1'b0;
                end
                step();
                cyc++;
            end
            bridge_wr = 1'b0;
            wr_accept = 1'b0;
            check("rand_issue_timeout", nw, 1000);
        end
        mem_ready = 1'b1;
        drain("rand_drain_timeout");
        check("rand_words", words_written, 32'd2000);
        check("rand_ovf", overflow, 1'b0);
        check("rand_oor", out_of_range, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
